// File: rtl/mem_bus_unit.sv
// mem_bus_unit: arbitrates instruction fetch and data load/store requests onto
// one shared memory bus with a ready handshake, a one-deep pending-fetch slot,
// an access timeout with a sticky error flag, and completion counters.
module mem_bus_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              bus_err,
  output logic              read_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  num_fetch,
  output logic [CNT_W-1:0]  num_dacc
);

  // A zero TIMEOUT still needs a 1-bit counter so the logic stays well formed.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W:0] TO_VAL = (WAIT_W + 1)'(TIMEOUT);

  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic [1:0] { T_FETCH, T_LOAD, T_STORE } acc_t;

  state_t            state_q, state_d;
  acc_t              type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W:0]   wait_inc;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              read_m_q, read_m_d;
  logic              write_m_q, write_m_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  num_fetch_q, num_fetch_d;
  logic [CNT_W-1:0]  num_dacc_q, num_dacc_d;

  assign wait_inc = {1'b0, wait_q} + (WAIT_W + 1)'(1);

  // Next-state logic: arbitration in IDLE, completion/timeout in ACCESS.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    num_fetch_d = num_fetch_q;
    num_dacc_d  = num_dacc_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (pend_q) begin
          // A deferred fetch goes first; new requests are ignored while it is pending.
          state_d = ACCESS;
          type_d  = T_FETCH;
          addr_d  = pend_addr_q;
          pend_d  = 1'b0;
        end else if (d_req) begin
          state_d = ACCESS;
          type_d  = d_we ? T_STORE : T_LOAD;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (if_req) begin
            pend_d      = 1'b1;
            pend_addr_d = if_addr;
          end
        end else if (if_req) begin
          state_d = ACCESS;
          type_d  = T_FETCH;
          addr_d  = if_addr;
        end
      end
      default: begin
        if (mem_ready) begin
          state_d = IDLE;
          wait_d  = '0;
          case (type_q)
            T_FETCH: begin
              if_rdata_d  = data;
              if_valid_d  = 1'b1;
              num_fetch_d = num_fetch_q + 1'b1;
            end
            T_LOAD: begin
              d_rdata_d  = data;
              d_valid_d  = 1'b1;
              num_dacc_d = num_dacc_q + 1'b1;
            end
            default: begin
              d_valid_d  = 1'b1;
              num_dacc_d = num_dacc_q + 1'b1;
            end
          endcase
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
          if ((TIMEOUT != 0) && (wait_inc == TO_VAL)) begin
            // Abort: report through the normal valid pulse but keep old read data.
            state_d   = IDLE;
            wait_d    = '0;
            bus_err_d = 1'b1;
            if (type_q == T_FETCH) if_valid_d = 1'b1;
            else                   d_valid_d  = 1'b1;
          end
        end
      end
    endcase
    read_m_d  = (state_d == ACCESS) && (type_d != T_STORE);
    write_m_d = (state_d == ACCESS) && (type_d == T_STORE);
  end

  // State and registered outputs; reset drops strobes at the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      type_q      <= T_FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      read_m_q    <= 1'b0;
      write_m_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      num_fetch_q <= '0;
      num_dacc_q  <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      read_m_q    <= read_m_d;
      write_m_q   <= write_m_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      num_fetch_q <= num_fetch_d;
      num_dacc_q  <= num_dacc_d;
    end
  end

  // The write strobe is high exactly in ACCESS/STORE, so it gates the bus driver.
  assign data      = write_m_q ? wdata_q : {DATA_W{1'bz}};
  assign address   = addr_q;
  assign read_m    = read_m_q;
  assign write_m   = write_m_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign num_fetch = num_fetch_q;
  assign num_dacc  = num_dacc_q;
  assign busy      = (state_q == ACCESS) || pend_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: main instance (TIMEOUT=4) plus a CNT_W=2
// instance sharing the same stimulus for the counter-wrap check.
module tb_mem_bus_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic        a_if_valid, a_d_valid, a_busy, a_bus_err, a_read_m, a_write_m;
  logic [15:0] a_if_rdata, a_d_rdata, a_address, a_num_fetch, a_num_dacc;
  wire  [15:0] a_data;

  logic        b_if_valid, b_d_valid, b_busy, b_bus_err, b_read_m, b_write_m;
  logic [15:0] b_if_rdata, b_d_rdata, b_address;
  logic [1:0]  b_num_fetch, b_num_dacc;
  wire  [15:0] b_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: returns mem_rdata on reads, releases the bus on writes,
  // and otherwise drives zero so any stray DUT drive shows up as nonzero.
  assign a_data = a_read_m ? mem_rdata : (a_write_m ? 16'hzzzz : 16'h0000);
  assign b_data = b_read_m ? mem_rdata : (b_write_m ? 16'hzzzz : 16'h0000);

  mem_bus_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(a_if_valid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(a_d_valid), .d_rdata(a_d_rdata), .busy(a_busy), .bus_err(a_bus_err),
    .read_m(a_read_m), .write_m(a_write_m), .address(a_address), .data(a_data),
    .mem_ready(mem_ready), .num_fetch(a_num_fetch), .num_dacc(a_num_dacc)
  );

  mem_bus_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4), .CNT_W(2)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(b_d_valid), .d_rdata(b_d_rdata), .busy(b_busy), .bus_err(b_bus_err),
    .read_m(b_read_m), .write_m(b_write_m), .address(b_address), .data(b_data),
    .mem_ready(mem_ready), .num_fetch(b_num_fetch), .num_dacc(b_num_dacc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("t=%0t check %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_read_m", a_read_m, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_address", a_address, 0);
    chk("rst_bus_err", a_bus_err, 0);
    chk("rst_num_fetch", a_num_fetch, 0);
    chk("rst_data_free", a_data, 0);
    reset_n = 1'b1;
    tick();

    // Fetch with ready held high
    if_req = 1'b1; if_addr = 16'h0010; mem_ready = 1'b1; mem_rdata = 16'h6A02;
    tick();
    if_req = 1'b0;
    chk("f1_read_m", a_read_m, 1);
    chk("f1_address", a_address, 16'h0010);
    chk("f1_busy", a_busy, 1);
    chk("f1_no_valid_yet", a_if_valid, 0);
    tick();
    chk("f1_if_valid", a_if_valid, 1);
    chk("f1_if_rdata", a_if_rdata, 16'h6A02);
    chk("f1_read_m_off", a_read_m, 0);
    chk("f1_num_fetch", a_num_fetch, 1);
    chk("f1_busy_off", a_busy, 0);
    tick();
    chk("f1_valid_pulse", a_if_valid, 0);
    chk("f1_rdata_hold", a_if_rdata, 16'h6A02);

    // Store with 3 wait states
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF; mem_ready = 1'b0;
    tick();
    d_req = 1'b0;
    chk("st_write_m", a_write_m, 1);
    chk("st_read_m", a_read_m, 0);
    chk("st_address", a_address, 16'h0100);
    chk("st_data", a_data, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_wait_write_m", a_write_m, 1);
      chk("st_wait_no_valid", a_d_valid, 0);
    end
    chk("st_wait_data", a_data, 16'hBEEF);
    mem_ready = 1'b1;
    tick();
    chk("st_d_valid", a_d_valid, 1);
    chk("st_write_m_off", a_write_m, 0);
    chk("st_data_released", a_data, 0);
    chk("st_num_dacc", a_num_dacc, 1);

    // Simultaneous load and fetch: load first, fetch replayed from the pending slot
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0002; mem_rdata = 16'h1234;
    tick();
    d_req = 1'b0; if_req = 1'b0;
    chk("sim_ld_read_m", a_read_m, 1);
    chk("sim_ld_address", a_address, 16'h0020);
    tick();
    chk("sim_d_valid", a_d_valid, 1);
    chk("sim_d_rdata", a_d_rdata, 16'h1234);
    chk("sim_busy_pending", a_busy, 1);
    chk("sim_no_if_valid", a_if_valid, 0);
    mem_rdata = 16'h4001;
    tick();
    chk("sim_f_read_m", a_read_m, 1);
    chk("sim_f_address", a_address, 16'h0002);
    chk("sim_f_busy", a_busy, 1);
    tick();
    chk("sim_if_valid", a_if_valid, 1);
    chk("sim_if_rdata", a_if_rdata, 16'h4001);
    chk("sim_busy_off", a_busy, 0);
    chk("sim_num_fetch", a_num_fetch, 2);
    chk("sim_num_dacc", a_num_dacc, 2);

    // Timeout on a fetch (TIMEOUT=4)
    if_req = 1'b1; if_addr = 16'h0030; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    tick();
    if_req = 1'b0;
    chk("to_read_m", a_read_m, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_read_m", a_read_m, 1);
      chk("to_wait_err", a_bus_err, 0);
    end
    tick();
    chk("to_if_valid", a_if_valid, 1);
    chk("to_read_m_off", a_read_m, 0);
    chk("to_bus_err", a_bus_err, 1);
    chk("to_rdata_kept", a_if_rdata, 16'h4001);
    chk("to_num_fetch", a_num_fetch, 2);
    tick();
    chk("to_err_sticky", a_bus_err, 1);
    chk("to_valid_pulse", a_if_valid, 0);

    // Reset in the 2nd ACCESS cycle of a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    tick();
    d_req = 1'b0;
    tick();
    chk("rm_read_m", a_read_m, 1);
    reset_n = 1'b0;
    tick();
    chk("rm_read_m_off", a_read_m, 0);
    chk("rm_write_m_off", a_write_m, 0);
    chk("rm_busy", a_busy, 0);
    chk("rm_d_valid", a_d_valid, 0);
    chk("rm_bus_err", a_bus_err, 0);
    chk("rm_data_free", a_data, 0);
    chk("rm_num_dacc", a_num_dacc, 0);
    reset_n = 1'b1; mem_ready = 1'b1;
    tick();
    chk("rm_no_late_valid", a_d_valid, 0);

    // Five fetches: CNT_W=2 wraps to 1, 16-bit counter reaches 5
    for (int i = 0; i < 5; i++) begin
      if_req = 1'b1; if_addr = 16'(i); mem_rdata = 16'(16'h0A00 + i);
      tick();
      if_req = 1'b0;
      tick();
      chk("wr_if_valid", a_if_valid, 1);
      chk("wr_if_rdata", a_if_rdata, 32'(16'h0A00 + i));
    end
    chk("wr_num_fetch_narrow", b_num_fetch, 1);
    chk("wr_num_fetch_wide", a_num_fetch, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
